// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - operand/select/result bus between the sequencer and the 8-bit ALU
interface alu_sequencer_if;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [2:0] alu_sel;
    logic [7:0] alu_out;
    logic       alu_zero;

    modport master (
        output alu_a,
        output alu_b,
        output alu_sel,
        input  alu_out,
        input  alu_zero
    );

    modport slave (
        input  alu_a,
        input  alu_b,
        input  alu_sel,
        output alu_out,
        output alu_zero
    );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - program-memory driven controller issuing ops to the 8-bit ALU
module alu_sequencer #(
    parameter int PC_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                prog_we,
    input  logic [PC_W-1:0]     prog_addr,
    input  logic [15:0]         prog_wdata,
    input  logic                start,
    alu_sequencer_if.master     alu,
    input  logic [1:0]          rd_addr,
    output logic [7:0]          rd_data,
    output logic [PC_W-1:0]     pc,
    output logic                zero_flag,
    output logic                busy,
    output logic                done,
    output logic                err
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CAPT, S_DONE} state_t;

    localparam logic [PC_W-1:0] PC_MAX = '1;

    state_t          state, next_state;
    logic [15:0]     mem [0:(1<<PC_W)-1];
    logic [7:0]      rf [4];
    logic [15:0]     instr;
    logic [1:0]      op;

    logic [PC_W-1:0] pc_next;
    logic            rf_we;
    logic [7:0]      rf_wdata;
    logic            zero_we;
    logic            alu_load;
    logic            err_set;
    logic            err_clr;
    logic            mem_we;
    logic            at_end;

    assign instr   = mem[pc];
    assign op      = instr[15:14];
    assign at_end  = (pc == PC_MAX);
    assign rd_data = rf[rd_addr];
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

    always_comb begin
        next_state = state;
        pc_next    = pc;
        rf_we      = 1'b0;
        rf_wdata   = instr[7:0];
        zero_we    = 1'b0;
        alu_load   = 1'b0;
        err_set    = 1'b0;
        err_clr    = 1'b0;
        mem_we     = 1'b0;
        case (state)
            S_IDLE: begin
                mem_we = prog_we;
                if (start) begin
                    next_state = S_EXEC;
                    pc_next    = '0;
                    err_clr    = 1'b1;
                end
            end
            S_EXEC: begin
                case (op)
                    2'b00: begin
                        alu_load   = 1'b1;
                        next_state = S_CAPT;
                    end
                    2'b01: begin
                        rf_we = 1'b1;
                        if (at_end) begin
                            next_state = S_DONE;
                            err_set    = 1'b1;
                        end else begin
                            pc_next = pc + 1'b1;
                        end
                    end
                    2'b10: begin
                        // A taken branch never counts as running off the end.
                        if (zero_flag) begin
                            pc_next = instr[PC_W-1:0];
                        end else if (at_end) begin
                            next_state = S_DONE;
                            err_set    = 1'b1;
                        end else begin
                            pc_next = pc + 1'b1;
                        end
                    end
                    default: next_state = S_DONE;
                endcase
            end
            S_CAPT: begin
                rf_we    = 1'b1;
                rf_wdata = alu.alu_out;
                zero_we  = 1'b1;
                if (at_end) begin
                    next_state = S_DONE;
                    err_set    = 1'b1;
                end else begin
                    next_state = S_EXEC;
                    pc_next    = pc + 1'b1;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= '0;
            zero_flag   <= 1'b0;
            err         <= 1'b0;
            alu.alu_a   <= '0;
            alu.alu_b   <= '0;
            alu.alu_sel <= '0;
            for (int i = 0; i < 4; i++) rf[i] <= '0;
        end else begin
            state <= next_state;
            pc    <= pc_next;
            if (rf_we)   rf[instr[10:9]] <= rf_wdata;
            if (zero_we) zero_flag <= alu.alu_zero;
            if (alu_load) begin
                alu.alu_a   <= rf[instr[8:7]];
                alu.alu_b   <= rf[instr[6:5]];
                alu.alu_sel <= instr[13:11];
            end
            if (err_clr)      err <= 1'b0;
            else if (err_set) err <= 1'b1;
        end
    end

    // Program memory is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[prog_addr] <= prog_wdata;
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed-vector bench for alu_sequencer with a reference ALU
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [15:0] prog_wdata;
    logic        start;
    logic [1:0]  rd_addr;
    logic [7:0]  rd_data;
    logic [3:0]  pc;
    logic        zero_flag;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    alu_sequencer_if alu_bus ();

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        case (s)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return {a[6:0], 1'b0};
            3'd6:    return {1'b0, a[7:1]};
            default: return ~a;
        endcase
    endfunction

    assign alu_bus.alu_out  = alu_ref(alu_bus.alu_a, alu_bus.alu_b, alu_bus.alu_sel);
    assign alu_bus.alu_zero = (alu_bus.alu_out == 8'h00);

    alu_sequencer #(.PC_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_wdata (prog_wdata),
        .start      (start),
        .alu        (alu_bus),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .pc         (pc),
        .zero_flag  (zero_flag),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [15:0] prog [16];
    logic [2:0]  sel_log [0:63];
    int          dcyc;
    logic        done_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
        rd_addr = idx;
        #1;
        chk(tag, {24'h0, rd_data}, {24'h0, exp});
    endtask

    function automatic logic [15:0] f_alu(input logic [2:0] s, input logic [1:0] d, input logic [1:0] a, input logic [1:0] b);
        return {2'b00, s, d, a, b, 5'b00000};
    endfunction

    function automatic logic [15:0] f_loadi(input logic [1:0] d, input logic [7:0] imm);
        return {2'b01, 3'b000, d, 1'b0, imm};
    endfunction

    function automatic logic [15:0] f_bz(input logic [3:0] t);
        return {2'b10, 10'h000, t};
    endfunction

    localparam logic [15:0] HALT = 16'hC000;

    task automatic load_prog;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            prog_we    = 1'b1;
            prog_addr  = 4'(i);
            prog_wdata = prog[i];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Cycle 1 is the cycle right after the edge that samples start.
    task automatic run(input logic pre_we, input logic [3:0] pre_addr, input logic [15:0] pre_data,
                       input int inj_cyc, input logic [3:0] inj_addr, input logic [15:0] inj_data,
                       output int done_cyc);
        @(negedge clk);
        start      = 1'b1;
        prog_we    = pre_we;
        prog_addr  = pre_addr;
        prog_wdata = pre_data;
        @(posedge clk);
        #1;
        start   = 1'b0;
        prog_we = 1'b0;
        done_cyc = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            sel_log[c] = alu_bus.alu_sel;
            if (done) begin
                done_cyc = c;
                break;
            end
            if (c == inj_cyc) begin
                start      = 1'b1;
                prog_we    = 1'b1;
                prog_addr  = inj_addr;
                prog_wdata = inj_data;
                @(posedge clk);
                #1;
                start   = 1'b0;
                prog_we = 1'b0;
            end
        end
        if (done_cyc > 0) begin
            @(negedge clk);
            chk("done_one_cycle", {31'h0, done}, 32'h0);
            chk("idle_after_done", {31'h0, busy}, 32'h0);
        end
    endtask

    task automatic set_bz_prog(input logic [7:0] r1_val);
        for (int i = 0; i < 16; i++) prog[i] = HALT;
        prog[0] = f_loadi(2'd0, 8'h05);
        prog[1] = f_loadi(2'd1, r1_val);
        prog[2] = f_alu(3'd1, 2'd2, 2'd0, 2'd1);
        prog[3] = f_bz(4'd5);
        prog[4] = f_loadi(2'd3, 8'hFF);
        prog[5] = HALT;
    endtask

    initial begin
        rst        = 1'b1;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_wdata = '0;
        start      = 1'b0;
        rd_addr    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        chk("rst_pc", {28'h0, pc}, 32'h0);
        chk("rst_zero", {31'h0, zero_flag}, 32'h0);
        chk("rst_alu_a", {24'h0, alu_bus.alu_a}, 32'h0);
        chk("rst_alu_b", {24'h0, alu_bus.alu_b}, 32'h0);
        chk("rst_alu_sel", {29'h0, alu_bus.alu_sel}, 32'h0);
        chk_reg("rst_r0", 2'd0, 8'h00);
        chk_reg("rst_r3", 2'd3, 8'h00);

        set_bz_prog(8'h05);
        load_prog();
        run(1'b0, 4'd0, 16'h0, 0, 4'd0, 16'h0, dcyc);
        chk("bz_taken_done_cyc", dcyc, 7);
        chk_reg("bz_taken_r2", 2'd2, 8'h00);
        chk_reg("bz_taken_r3", 2'd3, 8'h00);
        chk("bz_taken_zero", {31'h0, zero_flag}, 32'h1);
        chk("bz_taken_err", {31'h0, err}, 32'h0);
        chk("bz_taken_pc", {28'h0, pc}, 32'h5);

        set_bz_prog(8'h04);
        load_prog();
        run(1'b0, 4'd0, 16'h0, 0, 4'd0, 16'h0, dcyc);
        chk("bz_not_done_cyc", dcyc, 8);
        chk_reg("bz_not_r2", 2'd2, 8'h01);
        chk_reg("bz_not_r3", 2'd3, 8'hFF);
        chk("bz_not_zero", {31'h0, zero_flag}, 32'h0);
        chk("bz_not_pc", {28'h0, pc}, 32'h5);

        for (int i = 0; i < 16; i++) prog[i] = HALT;
        prog[0] = f_loadi(2'd0, 8'hF0);
        prog[1] = f_loadi(2'd1, 8'h20);
        prog[2] = f_alu(3'd0, 2'd2, 2'd0, 2'd1);
        prog[3] = f_loadi(2'd0, 8'h80);
        prog[4] = f_alu(3'd5, 2'd3, 2'd0, 2'd0);
        prog[5] = HALT;
        load_prog();
        run(1'b0, 4'd0, 16'h0, 0, 4'd0, 16'h0, dcyc);
        chk("ovf_done_cyc", dcyc, 9);
        chk_reg("ovf_r2", 2'd2, 8'h10);
        chk_reg("shl_r3", 2'd3, 8'h00);
        chk("shl_zero", {31'h0, zero_flag}, 32'h1);
        chk("add_sel_capt", {29'h0, sel_log[4]}, 32'h0);
        chk("shl_sel_capt", {29'h0, sel_log[7]}, 32'h5);

        for (int i = 0; i < 16; i++) prog[i] = f_loadi(2'd0, 8'h11);
        load_prog();
        run(1'b0, 4'd0, 16'h0, 0, 4'd0, 16'h0, dcyc);
        chk("runoff_done_cyc", dcyc, 17);
        chk("runoff_err", {31'h0, err}, 32'h1);
        chk_reg("runoff_r0", 2'd0, 8'h11);

        run(1'b1, 4'd0, HALT, 0, 4'd0, 16'h0, dcyc);
        chk("we_start_done_cyc", dcyc, 2);
        chk("we_start_err_clr", {31'h0, err}, 32'h0);
        chk("we_start_pc", {28'h0, pc}, 32'h0);

        set_bz_prog(8'h05);
        load_prog();
        run(1'b0, 4'd0, 16'h0, 2, 4'd5, f_loadi(2'd3, 8'h77), dcyc);
        chk("busy_ign_done_cyc", dcyc, 7);
        chk_reg("busy_ign_r3", 2'd3, 8'h00);
        run(1'b0, 4'd0, 16'h0, 0, 4'd0, 16'h0, dcyc);
        chk("busy_ign_rerun_cyc", dcyc, 7);
        chk("busy_ign_rerun_pc", {28'h0, pc}, 32'h5);
        chk_reg("busy_ign_rerun_r3", 2'd3, 8'h00);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("capt_busy", {31'h0, busy}, 32'h1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        chk("abort_zero", {31'h0, zero_flag}, 32'h0);
        chk("abort_pc", {28'h0, pc}, 32'h0);
        chk_reg("abort_r0", 2'd0, 8'h00);
        chk_reg("abort_r1", 2'd1, 8'h00);
        done_seen = done;
        repeat (10) begin
            @(negedge clk);
            done_seen = done_seen | done;
        end
        chk("abort_no_done", {31'h0, done_seen}, 32'h0);
        run(1'b0, 4'd0, 16'h0, 0, 4'd0, 16'h0, dcyc);
        chk("abort_rerun_cyc", dcyc, 7);
        chk_reg("abort_rerun_r2", 2'd2, 8'h00);
        chk("abort_rerun_zero", {31'h0, zero_flag}, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Initiator/controller for the 8-bit combinational ALU. Holds a small program memory and a 4x8 register file.
- Issues operand/select pairs to the ALU, captures its result and Zero flag, and branches on Zero.
- Sits above the ALU as the only agent driving its A, B and select inputs.

Parameters:
- PC_W, 4, program counter width; program memory depth = 2**PC_W words of 16 bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- prog_we  in  1  program memory write strobe; honoured only in IDLE.
- prog_addr  in  PC_W  program write address.
- prog_wdata  in  16  instruction word.
- start  in  1  begin execution at address 0; honoured only in IDLE.
- alu_a  out  8  ALU operand A (registered).
- alu_b  out  8  ALU operand B (registered).
- alu_sel  out  3  ALU select (registered).
- alu_out  in  8  ALU result.
- alu_zero  in  1  ALU Zero flag.
- rd_addr  in  2  register file read address.
- rd_data  out  8  combinational read of reg[rd_addr].
- pc  out  PC_W  current program counter.
- zero_flag  out  1  last captured ALU Zero.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at program end.
- err  out  1  set when execution runs off the end of memory; held until next accepted start.

Behaviour:
- Instruction encoding, instr[15:14]:
  - 00 ALU: sel=[13:11], dst=[10:9], srcA=[8:7], srcB=[6:5].
  - 01 LOADI: dst=[10:9], imm=[7:0].
  - 10 BZ: target=[PC_W-1:0].
  - 11 HALT.
  - Unused bits are ignored.
- ALU sel codes: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl1, 110 shr1, 111 not A. Results are 8-bit; carry/borrow discarded.
- States: IDLE, EXEC, CAPT, DONE.
- IDLE:
  - prog_we writes mem[prog_addr] at the edge.
  - start moves to EXEC with pc=0 and clears err.
  - prog_we and start in the same cycle: the write completes and start is accepted; the written word is visible to the first fetch.
- EXEC: instr = mem[pc], read asynchronously.
  - ALU: load alu_a=reg[srcA], alu_b=reg[srcB], alu_sel=sel; go to CAPT; pc unchanged.
  - LOADI: reg[dst]=imm; zero_flag unchanged; pc+1; stay in EXEC.
  - BZ: pc = target if zero_flag=1, else pc+1; stay in EXEC.
  - HALT: go to DONE; pc unchanged.
- CAPT: reg[dst]=alu_out, zero_flag=alu_zero, pc+1, return to EXEC. ALU ops take 2 cycles; LOADI, BZ and HALT take 1 cycle each.
- Run-off: any pc+1 increment from pc = 2**PC_W-1 (LOADI, not-taken BZ, CAPT) goes to DONE with err=1 instead of wrapping. A taken BZ never sets err.
- DONE: done=1 for exactly one cycle, then IDLE. pc, regs and zero_flag retain their values.
- Ignored inputs: start and prog_we while busy=1.
- Reset:
  - At the clock edge: state=IDLE, pc=0, all regs=0, zero_flag=0, alu_a=alu_b=0, alu_sel=0, busy=0, done=0, err=0.
  - Program memory is not reset.
  - Reset mid-run aborts immediately; no done pulse.
- alu_a, alu_b and alu_sel hold their last values outside EXEC->CAPT.
- Timing: with start sampled at edge k, the first instruction executes in cycle k+1.

Test Plan:
- Load program: [0] LOADI r0,0x05; [1] LOADI r1,0x05; [2] SUB r2=r0-r1; [3] BZ 5; [4] LOADI r3,0xFF; [5] HALT. Pulse start -> done high exactly 7 cycles after the start edge; r2=0x00, r3=0x00, zero_flag=1, err=0, pc=5.
- Same program with [1] LOADI r1,0x04 -> r2=0x01, zero_flag=0, BZ not taken, r3=0xFF, done 8 cycles after start.
- Overflow and shift: LOADI r0,0xF0; LOADI r1,0x20; ADD r2; LOADI r0,0x80; SHL r3=r0; HALT -> r2=0x10, r3=0x00, zero_flag=1. Also check alu_sel=101 is observed in the CAPT cycle.
- Run-off: fill all 16 words with LOADI r0,0x11 -> done after 17 cycles with err=1, r0=0x11. A following start clears err.
- start plus prog_we in the same IDLE cycle writing HALT at addr 0 -> done 2 cycles later. Also: prog_we and start asserted while busy -> memory unchanged, no restart.
- Assert rst in the CAPT cycle of an ALU op -> next cycle busy=0, regs=0, zero_flag=0, no done pulse; the program re-runs correctly on the next start.
